otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
Arbitrates the OTTER data-memory port (memory port 2) between the CPU control path and a debug/DMA requester. The CPU has priority, but a saturating wait counter guarantees the debug side a grant within a bounded number of cycles. While the debug side holds the port, the CPU is stalled so the control FSM can hold its execute/writeback state. The block sits between CU_FSM/datapath and the memory module.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_WAIT, 4, max cycles a pending debug request waits under CPU contention before a forced grant (>=1)

Ports:
clk  in  1  clock
RST  in  1  synchronous, active-high reset
cpu_rden  in  1  CPU read enable (memRDEN2)
cpu_we  in  1  CPU write enable (memWE2)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_size  in  2  CPU access size (00 byte, 01 half, 10 word)
cpu_sign  in  1  CPU load sign-extend flag
cpu_stall  out  1  CPU access not issued this cycle; CPU must hold request
cpu_rdata  out  DATA_W  CPU read data, pass-through of mem_rdata
dbg_req  in  1  debug request, level, held until dbg_ack
dbg_we  in  1  debug write(1)/read(0), stable while dbg_req
dbg_addr  in  ADDR_W  debug address, word accesses only
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  registered debug read data
mem_rden  out  1  memory read enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_size  out  2  memory access size
mem_sign  out  1  memory sign flag
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rden

Behaviour:
- Reset (RST=1 at posedge clk): state=IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0. Reset mid-access aborts the debug transaction with no ack; dbg_req must be re-presented.
- cpu_act = cpu_rden | cpu_we. If both are set, write wins: mem_rden is forced 0 for that access.
- States:
  - IDLE: debug grant allowed.
  - DRSP: debug response cycle.
- dbg_grant (combinational, IDLE only) = dbg_req & (~cpu_act | wait_cnt==MAX_WAIT).
- Port mux:
  - When dbg_grant=1: mem_* driven from dbg fields, mem_size=10, mem_sign=0, mem_rden=~dbg_we, mem_we=dbg_we, and cpu_stall=cpu_act.
  - Otherwise: mem_* = cpu_* with the write-wins rule, and cpu_stall=0.
- Idle outputs: with no grant and no cpu_act, mem_rden=0, mem_we=0; address and data follow the CPU inputs.
- Transitions:
  - IDLE with dbg_grant goes to DRSP.
  - IDLE without dbg_grant stays in IDLE.
  - DRSP always goes to IDLE.
- DRSP cycle:
  - dbg_ack=1 (registered; asserted exactly one cycle after the grant cycle).
  - On a debug read, dbg_rdata <= mem_rdata at the end of DRSP. dbg_rdata holds until the next debug read completes.
  - The CPU passes through to memory in DRSP; no debug grant is possible in DRSP.
- Latency:
  - Uncontended debug access: ack 1 cycle after dbg_req is seen in IDLE.
  - Read data is valid in dbg_rdata the cycle after ack.
- wait_cnt:
  - In IDLE with dbg_req=1 and no grant: increments, saturating at MAX_WAIT.
  - Cleared to 0 on grant, and whenever dbg_req=0.
- Bound: with the CPU active every cycle, grant occurs exactly MAX_WAIT cycles after dbg_req rises.
- cpu_rdata = mem_rdata always. Correctness relies on the CPU holding a stalled request; a CPU read issued in DRSP returns data the following cycle.
- dbg_req deasserted before ack:
  - In IDLE: the request is dropped and the counter cleared.
  - In DRSP: the access already issued completes and ack still pulses.

Test Plan:
- CPU only: cpu_rden=1, addr 0x100, size=10 for 3 cycles, dbg_req=0 -> mem_rden=1, mem_addr=0x100, cpu_stall=0 each cycle; cpu_rdata equals mem_rdata.
- Uncontended debug read: dbg_req=1, dbg_we=0, addr 0x200, mem returns 0xDEADBEEF -> grant cycle: mem_rden=1, mem_addr=0x200. Next cycle: dbg_ack=1. Cycle after: dbg_rdata=0xDEADBEEF.
- Starvation bound: cpu_we=1 continuously, dbg_req rises at cycle 0 with MAX_WAIT=4 -> cycles 0-3: CPU owns the port and wait_cnt goes 0,1,2,3. Cycle 4: debug granted and cpu_stall=1. Cycle 5: dbg_ack=1, cpu_stall=0.
- Debug write while CPU idle: dbg_we=1, addr 0x44, wdata 0x12345678 -> one cycle with mem_we=1, mem_addr=0x44, mem_wdata=0x12345678, mem_size=10; dbg_ack pulses one cycle later; dbg_rdata unchanged.
- Write-wins: cpu_rden=1 and cpu_we=1, addr 0x8 -> mem_we=1, mem_rden=0.
- Reset in DRSP: assert RST during the DRSP cycle -> next cycle state=IDLE, dbg_ack=0, dbg_rdata=0, wait_cnt=0.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares OTTER memory port 2 between the CPU and a debug/DMA requester
//    clk, RST                        clock, synchronous active-high reset
//    cpu_rden/we/addr/wdata/size/sign CPU request; cpu_stall holds it, cpu_rdata returns data
//    dbg_req/we/addr/wdata           debug word request, level until dbg_ack
//    dbg_ack, dbg_rdata              one-cycle completion pulse, registered read data
//    mem_*                           memory port 2 request, mem_rdata one cycle after mem_rden
module otter_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              cpu_rden,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [1:0]        cpu_size,
   input  logic              cpu_sign,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_rden,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mem_size,
   output logic              mem_sign,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAXW = MAX_WAIT[CW-1:0];
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] DRSP = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] wait_cnt;
   logic          dbg_rd;
   logic          cpu_act;
   logic          dbg_grant;

   assign cpu_act   = cpu_rden | cpu_we;
   // CPU keeps priority until the pending debug request has waited MAX_WAIT cycles
   assign dbg_grant = (state == IDLE) & dbg_req & (~cpu_act | (wait_cnt == MAXW));
   assign cpu_stall = dbg_grant & cpu_act;
   assign cpu_rdata = mem_rdata;

   // a simultaneous CPU read and write issues only the write
   always_comb begin
      mem_rden  = dbg_grant ? ~dbg_we : cpu_rden & ~cpu_we;
      mem_we    = dbg_grant ? dbg_we : cpu_we;
      mem_addr  = dbg_grant ? dbg_addr : cpu_addr;
      mem_wdata = dbg_grant ? dbg_wdata : cpu_wdata;
      mem_size  = dbg_grant ? 2'b10 : cpu_size;
      mem_sign  = dbg_grant ? 1'b0 : cpu_sign;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         dbg_ack   <= 1'b0;
         dbg_rd    <= 1'b0;
         dbg_rdata <= '0;
      end else begin
         state    <= dbg_grant ? DRSP : IDLE;
         dbg_ack  <= dbg_grant;
         dbg_rd   <= dbg_grant ? ~dbg_we : dbg_rd;
         wait_cnt <= (~dbg_req | dbg_grant) ? '0 :
                     (state == IDLE && wait_cnt != MAXW) ? wait_cnt + 1'b1 : wait_cnt;
         // read data arrives during the response cycle, after the issuing grant
         if (state == DRSP && dbg_rd)
            dbg_rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter: directed vectors and multi-cycle sequences for otter_mem_arbiter
module tb_otter_mem_arbiter;
   logic        clk = 0;
   logic        RST;
   logic        cpu_rden, cpu_we, cpu_sign, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [1:0]  cpu_size;
   logic        dbg_req, dbg_we, dbg_ack;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_rden, mem_we, mem_sign;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_size;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .RST(RST),
      .cpu_rden(cpu_rden), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_rden(mem_rden), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        c_rden, c_we;
      logic [31:0] c_addr, c_wdata;
      logic [1:0]  c_size;
      logic        c_sign;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata, m_rdata;
      logic [5:0]  e_ctl;
      logic [31:0] e_addr, e_wdata;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      cpu_rden = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0; cpu_sign = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      RST = 1;
      tick();
      RST = 0;
   endtask

   initial begin
      // e_ctl = {mem_rden, mem_we, mem_size, mem_sign, cpu_stall}
      vt[0] = '{1,0,32'h100,32'h0,2'b10,1, 0,0,32'h0,32'h0,32'h11, 6'b10_10_1_0, 32'h100, 32'h0};
      vt[1] = '{1,1,32'h8,32'hAA,2'b10,0, 0,0,32'h0,32'h0,32'h22, 6'b01_10_0_0, 32'h8, 32'hAA};
      vt[2] = '{0,0,32'h33,32'h77,2'b01,1, 0,0,32'h0,32'h0,32'h33, 6'b00_01_1_0, 32'h33, 32'h77};
      vt[3] = '{0,0,32'h50,32'h9,2'b00,1, 1,0,32'h200,32'h1,32'h44, 6'b10_10_0_0, 32'h200, 32'h1};
      vt[4] = '{0,0,32'h50,32'h9,2'b00,1, 1,1,32'h44,32'h12345678,32'h55, 6'b01_10_0_0, 32'h44, 32'h12345678};
      vt[5] = '{0,1,32'h10,32'h5,2'b00,0, 1,0,32'h20,32'h6,32'h66, 6'b01_00_0_0, 32'h10, 32'h5};
      vt[6] = '{1,0,32'h2,32'h0,2'b01,0, 0,1,32'h99,32'h0,32'h77, 6'b10_01_0_0, 32'h2, 32'h0};
      clr();
      do_reset();
      chk("reset_ack", {31'b0, dbg_ack}, 0);
      chk("reset_rdata", dbg_rdata, 0);
      chk("reset_wait", {29'b0, dut.wait_cnt}, 0);

      for (int i = 0; i < 7; i++) begin
         clr();
         do_reset();
         cpu_rden = vt[i].c_rden; cpu_we = vt[i].c_we; cpu_addr = vt[i].c_addr;
         cpu_wdata = vt[i].c_wdata; cpu_size = vt[i].c_size; cpu_sign = vt[i].c_sign;
         dbg_req = vt[i].d_req; dbg_we = vt[i].d_we; dbg_addr = vt[i].d_addr;
         dbg_wdata = vt[i].d_wdata; mem_rdata = vt[i].m_rdata;
         #1;
         chk($sformatf("vec%0d_ctl", i), {26'b0, mem_rden, mem_we, mem_size, mem_sign, cpu_stall}, {26'b0, vt[i].e_ctl});
         chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].e_wdata);
         chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vt[i].m_rdata);
      end

      clr();
      do_reset();
      cpu_rden = 1; cpu_addr = 32'h100; cpu_size = 2'b10;
      for (int k = 0; k < 3; k++) begin
         mem_rdata = 32'hA000 + k;
         #1;
         chk("cpu_only_rden", {31'b0, mem_rden}, 1);
         chk("cpu_only_addr", mem_addr, 32'h100);
         chk("cpu_only_stall", {31'b0, cpu_stall}, 0);
         chk("cpu_only_rdata", cpu_rdata, 32'hA000 + k);
         tick();
      end

      clr();
      do_reset();
      dbg_req = 1; dbg_addr = 32'h200; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("dr_grant_rden", {31'b0, mem_rden}, 1);
      chk("dr_grant_addr", mem_addr, 32'h200);
      chk("dr_grant_ack", {31'b0, dbg_ack}, 0);
      tick();
      chk("dr_ack", {31'b0, dbg_ack}, 1);
      dbg_req = 0;
      #1;
      chk("dr_drsp_rden", {31'b0, mem_rden}, 0);
      tick();
      chk("dr_ack_low", {31'b0, dbg_ack}, 0);
      chk("dr_rdata", dbg_rdata, 32'hDEADBEEF);

      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h44; dbg_wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
      #1;
      chk("dw_ctl", {26'b0, mem_rden, mem_we, mem_size, mem_sign, cpu_stall}, {26'b0, 6'b01_10_0_0});
      chk("dw_addr", mem_addr, 32'h44);
      chk("dw_wdata", mem_wdata, 32'h12345678);
      tick();
      chk("dw_ack", {31'b0, dbg_ack}, 1);
      dbg_req = 0;
      tick();
      chk("dw_ack_low", {31'b0, dbg_ack}, 0);
      chk("dw_rdata_hold", dbg_rdata, 32'hDEADBEEF);

      clr();
      do_reset();
      cpu_we = 1; cpu_addr = 32'h8; dbg_req = 1; dbg_addr = 32'h300;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("starve%0d_wait", k), {29'b0, dut.wait_cnt}, k);
         chk($sformatf("starve%0d_stall", k), {31'b0, cpu_stall}, 0);
         chk($sformatf("starve%0d_addr", k), mem_addr, 32'h8);
         tick();
      end
      #1;
      chk("starve4_stall", {31'b0, cpu_stall}, 1);
      chk("starve4_ctl", {30'b0, mem_rden, mem_we}, 2'b10);
      chk("starve4_addr", mem_addr, 32'h300);
      tick();
      chk("starve5_ack", {31'b0, dbg_ack}, 1);
      chk("starve5_stall", {31'b0, cpu_stall}, 0);
      chk("starve5_addr", mem_addr, 32'h8);
      dbg_req = 0;
      tick();
      chk("starve6_ack", {31'b0, dbg_ack}, 0);

      dbg_req = 1;
      tick();
      tick();
      chk("drop_wait2", {29'b0, dut.wait_cnt}, 2);
      dbg_req = 0;
      tick();
      chk("drop_wait0", {29'b0, dut.wait_cnt}, 0);
      chk("drop_no_ack", {31'b0, dbg_ack}, 0);

      clr();
      do_reset();
      dbg_req = 1; dbg_addr = 32'h200; mem_rdata = 32'h55;
      tick();
      chk("rst_drsp_ack", {31'b0, dbg_ack}, 1);
      RST = 1; dbg_req = 0;
      tick();
      RST = 0;
      chk("rst_state", {31'b0, dut.state}, 0);
      chk("rst_ack", {31'b0, dbg_ack}, 0);
      chk("rst_rdata", dbg_rdata, 0);
      chk("rst_wait", {29'b0, dut.wait_cnt}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
